// File: rtl/comfort_pkg.sv
// -----------------------------------------------------------------------------
// comfort_pkg
// Shared types and constants for the comfort controller: FSM state encoding,
// sensor range limits, humidity-compensation thresholds, fan gain and the
// reject limit, plus the COOL-state fan duty helper.
// -----------------------------------------------------------------------------
package comfort_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HOLD  = 3'd1,
        ST_HEAT  = 3'd2,
        ST_COOL  = 3'd3,
        ST_FAULT = 3'd4
    } state_e;

    localparam logic [7:0] DHT_TEMP_MAX   = 8'd50;
    localparam logic [7:0] DHT_HUM_MAX    = 8'd90;
    localparam logic [7:0] HUM_HI         = 8'd70;
    localparam logic [7:0] HUM_LO         = 8'd30;
    localparam int         FAN_GAIN_SHIFT = 5;
    localparam logic [1:0] REJECT_LIMIT   = 2'd3;

    // Fan duty for a temperature excess over setpoint: excess << gain,
    // saturated to 255, zero for no excess.
    function automatic logic [7:0] fan_duty(input logic signed [9:0] diff);
        logic [15:0] prod;
        prod = {6'b0, diff} << FAN_GAIN_SHIFT;
        if (diff <= 10'sd0) begin
            return 8'd0;
        end
        return (prod > 16'd255) ? 8'hFF : prod[7:0];
    endfunction

endpackage

// File: rtl/comfort_ctrl_fan_pwm.sv
// -----------------------------------------------------------------------------
// fan_pwm
// Free-running 8-bit PWM generator. The duty is latched only at counter wrap so
// a period is never cut short; output is registered.
//   i_clk   : system clock
//   i_rst_n : asynchronous active-low reset
//   i_duty  : requested duty (0..255), sampled at wrap
//   o_pwm   : PWM output, high for duty/256 of each period
// -----------------------------------------------------------------------------
module fan_pwm (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [7:0] i_duty,
    output logic       o_pwm
);

    logic [7:0] r_cnt;
    logic [7:0] r_duty_l;
    logic       r_pwm;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt    <= 8'd0;
            r_duty_l <= 8'd0;
            r_pwm    <= 1'b0;
        end else begin
            r_cnt <= r_cnt + 8'd1;
            if (r_cnt == 8'hFF) begin
                r_duty_l <= i_duty;
            end
            r_pwm <= (r_cnt < r_duty_l);
        end
    end

    assign o_pwm = r_pwm;

endmodule

// File: rtl/comfort_ctrl.sv
// -----------------------------------------------------------------------------
// comfort_ctrl
// Closed-loop comfort controller behind the DHT11 interface: captures readings
// on the rising edge of done_i, range-checks them, averages the last four good
// temperatures and runs a hysteresis thermostat driving heater and fan PWM.
// Falls back to FAULT (fan full, heater off, alarm) on bad or missing data.
//
// Optional feature macro: COMFORT_HUM_COMP_EN (humidity-compensated T_eff).
//
// Ports:
//   clk_i, rst_ni        : clock, asynchronous active-low reset
//   temp_i, hum_i        : sensor reading (degC, %RH)
//   done_i               : reading complete (level; rising edge captures)
//   setpoint_i, hyst_i   : target temperature and hysteresis band
//   heater_o             : heater enable (HEAT only)
//   fan_pwm_o            : fan PWM
//   fan_duty_o           : current fan duty
//   state_o              : FSM state
//   avg_temp_o           : 4-sample average temperature
//   alarm_o              : high in FAULT
//
// state | meaning
// IDLE  | after reset, no valid sample yet
// HOLD  | temperature inside the band, outputs off
// HEAT  | too cold, heater on until setpoint reached
// COOL  | too warm, fan duty proportional to excess
// FAULT | bad/missing data, fan full, heater off, alarm
// -----------------------------------------------------------------------------
module comfort_ctrl
    import comfort_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 250_000_000
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [7:0] temp_i,
    input  logic [7:0] hum_i,
    input  logic       done_i,
    input  logic [7:0] setpoint_i,
    input  logic [3:0] hyst_i,
    output logic       heater_o,
    output logic       fan_pwm_o,
    output logic [7:0] fan_duty_o,
    output logic [2:0] state_o,
    output logic [7:0] avg_temp_o,
    output logic       alarm_o
);

    localparam int WD_W = $clog2(TIMEOUT_CYC);
    // The kick cycle itself is the first counted clock, hence one less.
    localparam logic [WD_W-1:0] WD_RST_LD  = WD_W'(TIMEOUT_CYC - 1);
    localparam logic [WD_W-1:0] WD_KICK_LD = WD_W'(TIMEOUT_CYC - 2);

    logic              r_done_d;
    logic              r_cap;
    logic [7:0]        r_temp;
    logic [7:0]        r_hum;
    logic [1:0]        r_rej;
    logic              r_rej_flt;
    logic              r_eval;
    logic              r_first;
    logic [7:0]        r_buf [4];
    logic [9:0]        r_sum;
    logic [WD_W-1:0]   r_wd_cnt;
    state_e            r_state;
    logic [7:0]        r_duty;

    logic              w_edge;
    logic              w_kick;
    logic              w_cap_ok;
    logic              w_cap_bad;
    logic              w_wd_tc;
    logic [7:0]        w_avg;
    logic signed [9:0] w_teff;
    logic signed [9:0] w_sp;
    logic signed [9:0] w_lo;
    logic signed [9:0] w_hi;
    state_e            w_state_nxt;
    state_e            w_eval_st;
    logic [7:0]        w_duty_nxt;

    assign w_edge    = done_i & ~r_done_d;
    // Watchdog is kicked at the edge itself so a good sample arriving on the
    // expiry cycle pre-empts the FAULT entry.
    assign w_kick    = w_edge && (temp_i <= DHT_TEMP_MAX) && (hum_i <= DHT_HUM_MAX);
    assign w_cap_ok  = r_cap && (r_temp <= DHT_TEMP_MAX) && (r_hum <= DHT_HUM_MAX);
    assign w_cap_bad = r_cap && !w_cap_ok;
    assign w_wd_tc   = (r_wd_cnt == '0) && !w_kick;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_done_d <= 1'b0;
            r_cap    <= 1'b0;
            r_temp   <= 8'd0;
            r_hum    <= 8'd0;
        end else begin
            r_done_d <= done_i;
            r_cap    <= w_edge;
            if (w_edge) begin
                r_temp <= temp_i;
                r_hum  <= hum_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rej     <= 2'd0;
            r_rej_flt <= 1'b0;
            r_eval    <= 1'b0;
        end else begin
            r_eval    <= w_cap_ok;
            r_rej_flt <= 1'b0;
            if (w_cap_ok) begin
                r_rej <= 2'd0;
            end else if (w_cap_bad) begin
                if (r_rej != REJECT_LIMIT) begin
                    r_rej <= r_rej + 2'd1;
                end
                r_rej_flt <= (r_rej >= REJECT_LIMIT - 2'd1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < 4; i++) r_buf[i] <= 8'd0;
            r_sum   <= 10'd0;
            r_first <= 1'b1;
        end else if (w_cap_ok) begin
            r_first <= 1'b0;
            // Preload so the average starts at the first reading rather than
            // ramping up from stale or zero history.
            if (r_first || (r_state == ST_FAULT)) begin
                for (int i = 0; i < 4; i++) r_buf[i] <= r_temp;
                r_sum <= {r_temp, 2'b00};
            end else begin
                r_buf[0] <= r_temp;
                r_buf[1] <= r_buf[0];
                r_buf[2] <= r_buf[1];
                r_buf[3] <= r_buf[2];
                r_sum    <= r_sum - {2'b00, r_buf[3]} + {2'b00, r_temp};
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wd_cnt <= WD_RST_LD;
        end else if (w_kick) begin
            r_wd_cnt <= WD_KICK_LD;
        end else if (r_wd_cnt != '0) begin
            r_wd_cnt <= r_wd_cnt - 1'b1;
        end
    end

    assign w_avg = r_sum[9:2];

`ifdef COMFORT_HUM_COMP_EN
    logic [7:0] r_hum_acc;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_hum_acc <= 8'd0;
        end else if (w_cap_ok) begin
            r_hum_acc <= r_hum;
        end
    end

    always_comb begin
        w_teff = $signed({2'b00, w_avg});
        if ((r_hum_acc >= HUM_HI) && (w_avg != 8'hFF)) begin
            w_teff = w_teff + 10'sd1;
        end else if ((r_hum_acc <= HUM_LO) && (w_avg != 8'd0)) begin
            w_teff = w_teff - 10'sd1;
        end
    end
`else
    assign w_teff = $signed({2'b00, w_avg});
`endif

    assign w_sp = $signed({2'b00, setpoint_i});
    assign w_lo = w_sp - $signed({6'b0, hyst_i});
    assign w_hi = w_sp + $signed({6'b0, hyst_i});

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
            r_duty  <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_duty  <= w_duty_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_eval_st   = r_state;
        if (w_wd_tc || r_rej_flt) begin
            w_state_nxt = ST_FAULT;
        end else if (r_eval) begin
            if (r_state == ST_FAULT) begin
                // Recovery sample only re-arms; thermostat decides next strobe.
                w_state_nxt = ST_HOLD;
            end else begin
                w_eval_st   = (r_state == ST_IDLE) ? ST_HOLD : r_state;
                w_state_nxt = w_eval_st;
                case (w_eval_st)
                    ST_HOLD: begin
                        if (w_teff < w_lo)      w_state_nxt = ST_HEAT;
                        else if (w_teff > w_hi) w_state_nxt = ST_COOL;
                    end
                    ST_HEAT: begin
                        if (w_teff > w_hi)       w_state_nxt = ST_COOL;
                        else if (w_teff >= w_sp) w_state_nxt = ST_HOLD;
                    end
                    ST_COOL: begin
                        if (w_teff <= w_sp) w_state_nxt = ST_HOLD;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        w_duty_nxt = 8'd0;
        if (w_state_nxt == ST_COOL) begin
            w_duty_nxt = fan_duty(w_teff - w_sp);
        end else if (w_state_nxt == ST_FAULT) begin
            w_duty_nxt = 8'hFF;
        end
    end

    fan_pwm u_fan_pwm (
        .i_clk   (clk_i),
        .i_rst_n (rst_ni),
        .i_duty  (r_duty),
        .o_pwm   (fan_pwm_o)
    );

    assign heater_o   = (r_state == ST_HEAT);
    assign fan_duty_o = r_duty;
    assign state_o    = r_state;
    assign avg_temp_o = w_avg;
    assign alarm_o    = (r_state == ST_FAULT);

endmodule

// File: tb/tb_comfort_ctrl.sv
// -----------------------------------------------------------------------------
// tb_comfort_ctrl
// Self-checking bench for comfort_ctrl: directed scenarios plus randomized
// readings compared against a per-reading behavioural model.
// -----------------------------------------------------------------------------
module tb_comfort_ctrl;

    localparam int TO = 1000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] temp = 8'd0;
    logic [7:0] hum = 8'd0;
    logic       done = 1'b0;
    logic [7:0] setpoint = 8'd25;
    logic [3:0] hyst = 4'd2;
    logic       heater_o;
    logic       fan_pwm_o;
    logic [7:0] fan_duty_o;
    logic [2:0] state_o;
    logic [7:0] avg_temp_o;
    logic       alarm_o;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    int m_state;
    int m_rej;
    bit m_first;
    int m_q [4];
    int m_hum;

    comfort_ctrl #(.TIMEOUT_CYC(TO)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .temp_i     (temp),
        .hum_i      (hum),
        .done_i     (done),
        .setpoint_i (setpoint),
        .hyst_i     (hyst),
        .heater_o   (heater_o),
        .fan_pwm_o  (fan_pwm_o),
        .fan_duty_o (fan_duty_o),
        .state_o    (state_o),
        .avg_temp_o (avg_temp_o),
        .alarm_o    (alarm_o)
    );

    always #10 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "simulation time limit");
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic int m_avg();
        return (m_q[0] + m_q[1] + m_q[2] + m_q[3]) / 4;
    endfunction

    function automatic int m_teff();
        int a;
        a = m_avg();
`ifdef COMFORT_HUM_COMP_EN
        if (m_hum >= 70)      a = (a >= 255) ? 255 : a + 1;
        else if (m_hum <= 30) a = (a <= 0) ? 0 : a - 1;
`endif
        return a;
    endfunction

    function automatic int m_duty();
        int d;
        if (m_state == 4) return 255;
        if (m_state != 3) return 0;
        d = (m_teff() - int'(setpoint)) * 32;
        if (d > 255) d = 255;
        if (d < 0) d = 0;
        return d;
    endfunction

    task automatic model_reset();
        m_state = 0;
        m_rej   = 0;
        m_first = 1'b1;
        m_hum   = 0;
        for (int i = 0; i < 4; i++) m_q[i] = 0;
    endtask

    task automatic model_sample(input int t, input int h);
        int te;
        int sp;
        int hy;
        sp = int'(setpoint);
        hy = int'(hyst);
        if (t <= 50 && h <= 90) begin
            m_rej = 0;
            m_hum = h;
            if (m_first || m_state == 4) begin
                for (int i = 0; i < 4; i++) m_q[i] = t;
            end else begin
                for (int i = 3; i > 0; i--) m_q[i] = m_q[i-1];
                m_q[0] = t;
            end
            m_first = 1'b0;
            te = m_teff();
            if (m_state == 4) begin
                m_state = 1;
            end else begin
                if (m_state == 0) m_state = 1;
                case (m_state)
                    1: if (te < sp - hy) m_state = 2; else if (te > sp + hy) m_state = 3;
                    2: if (te > sp + hy) m_state = 3; else if (te >= sp) m_state = 1;
                    3: if (te <= sp) m_state = 1;
                    default: ;
                endcase
            end
        end else begin
            if (m_rej < 3) m_rej++;
            if (m_rej >= 3) m_state = 4;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".state"},  32'(state_o),    32'(m_state));
        chk({tag, ".heater"}, 32'(heater_o),   32'(m_state == 2));
        chk({tag, ".duty"},   32'(fan_duty_o), 32'(m_duty()));
        chk({tag, ".avg"},    32'(avg_temp_o), 32'(m_avg()));
        chk({tag, ".alarm"},  32'(alarm_o),    32'(m_state == 4));
    endtask

    // Called at a negedge; returns at the negedge three cycles after the edge.
    task automatic send(input int t, input int h);
        temp = 8'(t);
        hum  = 8'(h);
        done = 1'b1;
        @(posedge clk);
        @(negedge clk);
        done = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        model_sample(t, h);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        done  = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic count_pwm(output int n);
        n = 0;
        repeat (256) begin
            @(negedge clk);
            n += int'(fan_pwm_o);
        end
    endtask

    initial begin
        int n_hi;
        int t;
        int h;

        // reset values
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst.state", 32'(state_o), 0);
        chk("rst.heater", 32'(heater_o), 0);
        chk("rst.duty", 32'(fan_duty_o), 0);
        chk("rst.avg", 32'(avg_temp_o), 0);
        chk("rst.alarm", 32'(alarm_o), 0);
        chk("rst.pwm", 32'(fan_pwm_o), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // heat from cold, with latency
        temp = 8'd20; hum = 8'd50; done = 1'b1;
        @(posedge clk);
        @(negedge clk);
        done = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("heat.avg_c2", 32'(avg_temp_o), 20);
        chk("heat.state_c2", 32'(state_o), 0);
        @(posedge clk);
        @(negedge clk);
        model_sample(20, 50);
        chk("heat.state", 32'(state_o), 2);
        chk("heat.heater", 32'(heater_o), 1);
        check_all("heat");

        // cool via averaging
        do_reset();
        send(25, 50);
        check_all("cool0");
        send(33, 50);
        chk("cool1.avg", 32'(avg_temp_o), 27);
        check_all("cool1");
        send(33, 50);
        chk("cool2.state", 32'(state_o), 3);
        chk("cool2.duty", 32'(fan_duty_o), 128);
        check_all("cool2");
        repeat (300) @(negedge clk);
        count_pwm(n_hi);
        chk("cool2.pwm_hi", 32'(n_hi), 128);

        // reject and recover
        do_reset();
        send(25, 50);
        for (int i = 0; i < 3; i++) begin
            send(60, 50);
            check_all("rej");
        end
        chk("rej.state", 32'(state_o), 4);
        chk("rej.duty", 32'(fan_duty_o), 255);
        repeat (300) @(negedge clk);
        count_pwm(n_hi);
        chk("rej.pwm_hi", 32'(n_hi), 255);
        @(negedge clk);
        send(25, 50);
        chk("recov.alarm", 32'(alarm_o), 0);
        chk("recov.avg", 32'(avg_temp_o), 25);
        check_all("recov");

        // watchdog expiry exactly TO clocks after a good edge
        do_reset();
        send(25, 50);
        repeat (TO - 4) @(posedge clk);
        @(negedge clk);
        chk("wd.before", 32'(state_o), 1);
        @(posedge clk);
        @(negedge clk);
        chk("wd.expired", 32'(state_o), 4);
        chk("wd.alarm", 32'(alarm_o), 1);

        // good edge on the expiry cycle wins
        do_reset();
        send(25, 50);
        repeat (TO - 4) @(posedge clk);
        @(negedge clk);
        send(25, 50);
        check_all("wd_kick");
        repeat (20) @(negedge clk);
        chk("wd_kick.later", 32'(state_o), 1);

        // done held high: one capture only
        do_reset();
        send(25, 50);
        temp = 8'd33; hum = 8'd50; done = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        done = 1'b0;
        repeat (4) @(negedge clk);
        model_sample(33, 50);
        chk("edge.avg", 32'(avg_temp_o), 27);
        check_all("edge");

        // humidity compensation
        do_reset();
        send(27, 50);
        check_all("hum0");
        send(27, 80);
`ifdef COMFORT_HUM_COMP_EN
        chk("hum.state", 32'(state_o), 3);
        chk("hum.duty", 32'(fan_duty_o), 96);
`else
        chk("hum.state", 32'(state_o), 1);
        chk("hum.duty", 32'(fan_duty_o), 0);
`endif
        check_all("hum1");

        // asynchronous reset mid-operation, next sample preloads
        send(40, 50);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #2;
        chk("mid.state", 32'(state_o), 0);
        chk("mid.avg", 32'(avg_temp_o), 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        send(30, 50);
        chk("mid.avg_pre", 32'(avg_temp_o), 30);
        check_all("mid");

        // randomized readings
        do_reset();
        setpoint = 8'($urandom_range(20, 30));
        hyst     = 4'($urandom_range(0, 5));
        @(negedge clk);
        for (int k = 0; k < 300; k++) begin
            case ($urandom_range(0, 9))
                0: begin t = $urandom_range(51, 80); h = $urandom_range(0, 90); end
                1: begin t = $urandom_range(0, 50);  h = $urandom_range(91, 99); end
                default: begin t = $urandom_range(10, 40); h = $urandom_range(0, 90); end
            endcase
            send(t, h);
            check_all("rnd");
            repeat ($urandom_range(2, 20)) @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
